// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit frame deframer with
// parity/stop/timeout checking, and a first-word-fall-through byte FIFO.
module ps2_kbd_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic       PS2_clk,
  input  logic       PS2_Data,
  input  logic       rd_en,
  input  logic       ovf_clr,
  output logic [7:0] data_out,
  output logic       ready,
  output logic       overflow,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  logic          fall;

  // Synchronizers and the clock glitch filter idle at the bus level (1).
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
    end else begin
      clk_s1_q <= PS2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2_Data;
      dat_s2_q <= dat_s1_q;
      if (clk_s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q <= clk_s2_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  // fall is high in the cycle whose edge drops the filtered clock.
  assign fall = filt_q & ~clk_s2_q & (fcnt_q == FW'(FILTER_LEN - 1));

  state_t        state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tcnt_q;
  logic          perr_q;
  logic          ferr_q;
  logic          push;

  assign push = fall & (state_q == STOP) & dat_s2_q & (^{shift_q, par_q});

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tcnt_q   <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      if (fall || state_q == IDLE) begin
        tcnt_q <= '0;
      end else begin
        tcnt_q <= tcnt_q + 1'b1;
      end
      if (fall) begin
        case (state_q)
          IDLE: begin
            if (!dat_s2_q) begin
              state_q  <= DATA;
              bitcnt_q <= '0;
              shift_q  <= '0;
            end
          end
          DATA: begin
            shift_q[bitcnt_q] <= dat_s2_q;
            bitcnt_q          <= bitcnt_q + 1'b1;
            if (bitcnt_q == 3'd7) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!dat_s2_q) begin
              ferr_q <= 1'b1;
            end else if (!(^{shift_q, par_q})) begin
              perr_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE && tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
        state_q  <= IDLE;
        ferr_q   <= 1'b1;
        shift_q  <= '0;
        bitcnt_q <= '0;
      end
    end
  end

  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

  // rd_en pops the head only when ready is high; a pop and a push in the
  // same cycle both take effect, so a full FIFO can still accept a byte.
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;
  logic        empty, full, pop, wr_en, ovf_set;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = rd_en & ~empty;
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end
  end

  assign data_out = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign ready    = ~empty;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: framing, errors, glitch filter, timeout,
// FIFO fill/overflow/simultaneous push-pop, and asynchronous reset.
module tb_ps2_kbd_rx;

  localparam int TOUT = 300;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] data_out;
  logic       ready, overflow, parity_err, frame_err;

  ps2_kbd_rx #(
    .FILTER_LEN (8),
    .TIMEOUT_CYC(TOUT),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_50mhz (clk),
    .rst       (rst),
    .PS2_clk   (ps2_clk),
    .PS2_Data  (ps2_dat),
    .rd_en     (rd_en),
    .ovf_clr   (ovf_clr),
    .data_out  (data_out),
    .ready     (ready),
    .overflow  (overflow),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0, fall_cnt = 0, last_fall_cyc = 0;
  int pe_cnt = 0, fe_cnt = 0, fe_cyc = 0;
  int pe0, fe0, f0;

  // Event monitor: counts filtered falls and cycles with each error pulse high.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dut.fall) begin
      fall_cnt      = fall_cnt + 1;
      last_fall_cyc = cyc;
    end
    if (parity_err) pe_cnt = pe_cnt + 1;
    if (frame_err) begin
      fe_cnt = fe_cnt + 1;
      fe_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_raw(input logic [10:0] f, input int nbits, input int glitch_bit,
                          input bit pop_on_stop);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      if (i == glitch_bit) begin
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF - 10) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b0;
      if (pop_on_stop && i == 10) begin
        for (int k = 0; k < 40 && !dut.fall; k++) @(negedge clk);
        chk("stop_fall_seen", {31'd0, dut.fall}, 32'd1);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_v,
                            input int glitch_bit, input bit pop_on_stop);
    logic [10:0] f;
    f = {stop_v, (~^b) ^ bad_par, b, 1'b0};
    send_raw(f, 11, glitch_bit, pop_on_stop);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data_out", {24'd0, data_out}, 32'h0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_state", {30'd0, dut.state_q}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Good frame 0x1C, then pop back to empty.
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, -1, 1'b0);
    chk("t1_ready", {31'd0, ready}, 32'd1);
    chk("t1_data", {24'd0, data_out}, 32'h1C);
    chk("t1_no_err", pe_cnt + fe_cnt - pe0 - fe0, 32'd0);
    pop_one();
    chk("t1_ready_after_pop", {31'd0, ready}, 32'd0);
    chk("t1_data_after_pop", {24'd0, data_out}, 32'h0);

    // Bad parity, then 0xF0.
    pe0 = pe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, -1, 1'b0);
    chk("t2_parity_pulse_cycles", pe_cnt - pe0, 32'd1);
    chk("t2_ready_stays_0", {31'd0, ready}, 32'd0);
    send_frame(8'hF0, 1'b0, 1'b1, -1, 1'b0);
    chk("t2_data_f0", {24'd0, data_out}, 32'hF0);
    chk("t2_no_more_perr", pe_cnt - pe0, 32'd1);
    pop_one();

    // Bad stop bit: frame_err only.
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h33, 1'b0, 1'b0, -1, 1'b0);
    chk("stop0_frame_err", fe_cnt - fe0, 32'd1);
    chk("stop0_no_perr", pe_cnt - pe0, 32'd0);
    chk("stop0_ready", {31'd0, ready}, 32'd0);

    // Glitches shorter than the filter produce no falls.
    f0 = fall_cnt;
    ps2_clk = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3_idle_glitch_falls", fall_cnt - f0, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 4, 1'b0);
    chk("t3_frame_falls", fall_cnt - f0, 32'd11);
    chk("t3_data_5a", {24'd0, data_out}, 32'h5A);
    pop_one();

    // Partial frame then timeout.
    fe0 = fe_cnt;
    send_raw({1'b1, 1'b0, 8'h29, 1'b0}, 5, -1, 1'b0);
    for (int k = 0; k < TOUT + 100 && fe_cnt == fe0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("t4_timeout_pulse", fe_cnt - fe0, 32'd1);
    chk("t4_timeout_delay", fe_cyc - last_fall_cyc, TOUT + 1);
    chk("t4_state_idle", {30'd0, dut.state_q}, 32'd0);
    chk("t4_ready", {31'd0, ready}, 32'd0);
    send_frame(8'h29, 1'b0, 1'b1, -1, 1'b0);
    chk("t4_data_29", {24'd0, data_out}, 32'h29);
    chk("t4_no_extra_ferr", fe_cnt - fe0, 32'd1);
    pop_one();

    // Nine frames into an 8-deep FIFO.
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b0, 1'b1, -1, 1'b0);
      if (i == 8) chk("t5_ovf_after_8", {31'd0, overflow}, 32'd0);
    end
    chk("t5_ovf_after_9", {31'd0, overflow}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("t5_pop_data", {24'd0, data_out}, i);
      pop_one();
    end
    chk("t5_empty_ready", {31'd0, ready}, 32'd0);
    chk("t5_empty_data", {24'd0, data_out}, 32'h0);
    chk("t5_ovf_sticky", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t5_ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b1, -1, 1'b0);
    send_frame(8'h77, 1'b0, 1'b1, -1, 1'b1);
    chk("t6_no_ovf_push_pop", {31'd0, overflow}, 32'd0);
    send_frame(8'h88, 1'b0, 1'b1, -1, 1'b0);
    chk("t6_ovf_on_88", {31'd0, overflow}, 32'd1);
    for (int i = 1; i <= 7; i++) begin
      chk("t6_pop_data", {24'd0, data_out}, 32'h10 + i);
      pop_one();
    end
    chk("t6_last_is_77", {24'd0, data_out}, 32'h77);
    pop_one();
    chk("t6_empty", {31'd0, ready}, 32'd0);

    // Asynchronous reset mid-frame.
    send_frame(8'h42, 1'b0, 1'b1, -1, 1'b0);
    chk("rst2_pre_ready", {31'd0, ready}, 32'd1);
    send_raw({1'b1, 1'b1, 8'hA5, 1'b0}, 4, -1, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst2_data_out", {24'd0, data_out}, 32'h0);
    chk("rst2_ready", {31'd0, ready}, 32'd0);
    chk("rst2_overflow", {31'd0, overflow}, 32'd0);
    chk("rst2_errs", {30'd0, parity_err, frame_err}, 32'd0);
    chk("rst2_state", {30'd0, dut.state_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    fe0 = fe_cnt; pe0 = pe_cnt;
    send_frame(8'h3C, 1'b0, 1'b1, -1, 1'b0);
    chk("rst2_data_3c", {24'd0, data_out}, 32'h3C);
    chk("rst2_ready_after", {31'd0, ready}, 32'd1);
    chk("rst2_no_err", pe_cnt + fe_cnt - pe0 - fe0, 32'd0);
    pop_one();
    chk("rst2_empty", {31'd0, ready}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
